cpu_trace_buffer: RTL and testbench

- Hardware successor to per-cycle register printing. Samples the CPU's PC and a parametrised set of architectural registers every clock. Logs register-change events into an on-chip FIFO. Drains them over a valid/ready port.
- Sits beside single_top and pipelined variants, fed from debug taps: s0-s7 and t0-t9 are channels 0-17.
- Adds what the print loop lacks: change detection, timestamping, capture modes, buffering and overflow accounting.

---
 rtl/trace_pkg.sv | 44 ++++
 rtl/sync_fifo.sv | 54 +++++
 rtl/cpu_trace_buffer.sv | 155 +++++++++++++++
 tb/tb_cpu_trace_buffer.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/trace_pkg.sv
// Shared types and constants for the CPU trace path: entry layout, capture modes
// and the default debug-tap channel map (s0-s7, t0-t9).
package trace_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_NUM_CH = 18;
  localparam int DEF_TS_W   = 16;
  localparam int DEF_IDX_W  = $clog2(DEF_NUM_CH);

  typedef enum logic {
    MODE_ALL    = 1'b0,
    MODE_CHANGE = 1'b1
  } trace_mode_e;

  localparam int CH_S0 = 0;
  localparam int CH_S1 = 1;
  localparam int CH_S2 = 2;
  localparam int CH_S3 = 3;
  localparam int CH_S4 = 4;
  localparam int CH_S5 = 5;
  localparam int CH_S6 = 6;
  localparam int CH_S7 = 7;
  localparam int CH_T0 = 8;
  localparam int CH_T1 = 9;
  localparam int CH_T2 = 10;
  localparam int CH_T3 = 11;
  localparam int CH_T4 = 12;
  localparam int CH_T5 = 13;
  localparam int CH_T6 = 14;
  localparam int CH_T7 = 15;
  localparam int CH_T8 = 16;
  localparam int CH_T9 = 17;

  // Entry layout for the default channel configuration.
  typedef struct packed {
    logic [DEF_TS_W-1:0]   ts;
    logic [DEF_DATA_W-1:0] pc;
    logic [DEF_IDX_W-1:0]  idx;
    logic [DEF_DATA_W-1:0] val;
    logic                  chg;
    logic                  multi;
  } trace_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with no fall-through: a push becomes visible the cycle after.
// Head data reads as zero while empty; level uses an extra wrap bit on the pointers.
module sync_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [DATA_W-1:0]          push_data,
  input  logic                       rd_ready,
  output logic                       rd_valid,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign level    = wr_ptr - rd_ptr;
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_valid = !empty;
  assign do_pop   = rd_valid && rd_ready;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign do_push  = push && (!full || do_pop);
  assign rd_data  = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; empty masks stale contents, and
  // leaving it reset-free lets it map onto plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/cpu_trace_buffer.sv
// Samples PC and architectural register taps each cycle, detects changes against
// shadow copies, and buffers timestamped trace entries for a valid/ready consumer.
module cpu_trace_buffer
  import trace_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NUM_CH = 18,
  parameter int DEPTH  = 16,
  parameter int TS_W   = 16,
  parameter int IDX_W  = $clog2(NUM_CH)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cap_en,
  input  logic                      mode,
  input  logic [DATA_W-1:0]         pc_in,
  input  logic [NUM_CH*DATA_W-1:0]  regs_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [TS_W-1:0]           out_ts,
  output logic [DATA_W-1:0]         out_pc,
  output logic [IDX_W-1:0]          out_idx,
  output logic [DATA_W-1:0]         out_val,
  output logic                      out_chg,
  output logic                      out_multi,
  output logic                      overflow,
  output logic [15:0]               drop_cnt,
  output logic [$clog2(DEPTH):0]    level
);

  typedef struct packed {
    logic [TS_W-1:0]   ts;
    logic [DATA_W-1:0] pc;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] val;
    logic              chg;
    logic              multi;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);

  logic [TS_W-1:0]    ts;
  logic [DATA_W-1:0]  chan   [NUM_CH];
  logic [DATA_W-1:0]  shadow [NUM_CH];
  logic               primed;
  logic [NUM_CH-1:0]  chg;
  logic [IDX_W-1:0]   first_idx;
  logic [DATA_W-1:0]  first_val;
  logic               any_chg;
  logic               multi_chg;
  logic               push_req;
  logic               pop_fire;
  logic               drop;
  logic               fifo_full;
  logic               fifo_empty;
  entry_t             push_entry;
  entry_t             head_entry;
  logic [ENTRY_W-1:0] push_data;
  logic [ENTRY_W-1:0] head_data;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_chan
    assign chan[k] = regs_in[k*DATA_W +: DATA_W];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ts <= '0;
    else       ts <= ts + 1'b1;
  end

  // The first enabled cycle only seeds the shadows; primed survives cap_en drops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      primed <= 1'b0;
      for (int k = 0; k < NUM_CH; k++) shadow[k] <= '0;
    end else if (cap_en) begin
      primed <= 1'b1;
      for (int k = 0; k < NUM_CH; k++) shadow[k] <= chan[k];
    end
  end

  // NOTE: every signal driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    chg       = '0;
    first_idx = '0;
    first_val = '0;
    any_chg   = 1'b0;
    multi_chg = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      chg[k] = primed && cap_en && (chan[k] != shadow[k]);
    end
    for (int k = 0; k < NUM_CH; k++) begin
      if (chg[k]) begin
        if (any_chg) begin
          multi_chg = 1'b1;
        end else begin
          first_idx = IDX_W'(k);
          first_val = chan[k];
        end
        any_chg = 1'b1;
      end
    end
  end

  assign push_req = primed && cap_en &&
                    ((trace_mode_e'(mode) == MODE_ALL) || any_chg);
  assign pop_fire = out_valid && out_ready;
  assign drop     = push_req && fifo_full && !pop_fire;

  always_comb begin
    push_entry.ts    = ts;
    push_entry.pc    = pc_in;
    push_entry.idx   = first_idx;
    push_entry.val   = first_val;
    push_entry.chg   = any_chg;
    push_entry.multi = multi_chg;
  end

  assign push_data  = push_entry;
  assign head_entry = head_data;

  sync_fifo #(
    .DATA_W (ENTRY_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (reset),
    .push      (push_req),
    .push_data (push_data),
    .rd_ready  (out_ready),
    .rd_valid  (out_valid),
    .rd_data   (head_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (level)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 1'b1;
    end
  end

  assign out_ts    = head_entry.ts;
  assign out_pc    = head_entry.pc;
  assign out_idx   = head_entry.idx;
  assign out_val   = head_entry.val;
  assign out_chg   = head_entry.chg;
  assign out_multi = head_entry.multi;

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Directed bench for cpu_trace_buffer: stimulus pushes expected entries into a
// queue and a negedge monitor compares every accepted head entry against it.
module tb_cpu_trace_buffer;
  import trace_pkg::*;

  localparam int DATA_W = 32;
  localparam int NUM_CH = 18;
  localparam int DEPTH  = 16;
  localparam int TS_W   = 16;
  localparam int IDX_W  = 5;

  logic                     clk;
  logic                     reset;
  logic                     cap_en;
  logic                     mode;
  logic [DATA_W-1:0]        pc_in;
  logic [NUM_CH*DATA_W-1:0] regs_in;
  logic                     out_valid;
  logic                     out_ready;
  logic [TS_W-1:0]          out_ts;
  logic [DATA_W-1:0]        out_pc;
  logic [IDX_W-1:0]         out_idx;
  logic [DATA_W-1:0]        out_val;
  logic                     out_chg;
  logic                     out_multi;
  logic                     overflow;
  logic [15:0]              drop_cnt;
  logic [4:0]               level;

  logic [DATA_W-1:0] ch [NUM_CH];
  trace_entry_t      exp_q [$];
  logic [TS_W-1:0]   ts_model;
  int                checks;
  int                errors;

  cpu_trace_buffer #(
    .DATA_W (DATA_W),
    .NUM_CH (NUM_CH),
    .DEPTH  (DEPTH),
    .TS_W   (TS_W),
    .IDX_W  (IDX_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cap_en    (cap_en),
    .mode      (mode),
    .pc_in     (pc_in),
    .regs_in   (regs_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ts    (out_ts),
    .out_pc    (out_pc),
    .out_idx   (out_idx),
    .out_val   (out_val),
    .out_chg   (out_chg),
    .out_multi (out_multi),
    .overflow  (overflow),
    .drop_cnt  (drop_cnt),
    .level     (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    regs_in = '0;
    for (int k = 0; k < NUM_CH; k++) regs_in[k*DATA_W +: DATA_W] = ch[k];
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    if (!reset) ts_model++;
    #1;
  endtask

  function automatic trace_entry_t mk(input logic [15:0] ts, input logic [31:0] pc,
                                      input logic [4:0] idx, input logic [31:0] val,
                                      input logic chg, input logic multi);
    trace_entry_t e;
    e.ts = ts; e.pc = pc; e.idx = idx; e.val = val; e.chg = chg; e.multi = multi;
    return e;
  endfunction

  task automatic drain(input int budget);
    int n;
    n = 0;
    cap_en    = 1'b0;
    out_ready = 1'b1;
    while (level != 0 && n < budget) begin
      cyc();
      n++;
    end
    check("drain_level", 128'(level), 128'(0));
    check("drain_queue", 128'(exp_q.size()), 128'(0));
  endtask

  // Monitor: every accepted head entry must match the oldest expected entry.
  always @(negedge clk) begin
    trace_entry_t act;
    if (!reset && out_valid && out_ready) begin
      act = mk(out_ts, out_pc, out_idx, out_val, out_chg, out_multi);
      if (exp_q.size() == 0) check("unexpected_entry", 128'(act), 128'(0));
      else                   check("entry", 128'(act), 128'(exp_q.pop_front()));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks    = 0;
    errors    = 0;
    ts_model  = '0;
    reset     = 1'b1;
    cap_en    = 1'b0;
    mode      = 1'b1;
    pc_in     = '0;
    out_ready = 1'b0;
    for (int k = 0; k < NUM_CH; k++) ch[k] = 32'h1000 + k;
    ch[3] = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 128'(out_valid), 128'(0));
    check("rst_level", 128'(level), 128'(0));
    check("rst_overflow", 128'(overflow), 128'(0));
    check("rst_drop_cnt", 128'(drop_cnt), 128'(0));
    check("rst_ts", 128'(out_ts), 128'(0));

    // Change mode with constant registers: priming plus quiet cycles log nothing.
    reset  = 1'b0;
    cap_en = 1'b1;
    mode   = MODE_CHANGE;
    repeat (5) cyc();
    check("quiet_level", 128'(level), 128'(0));
    check("quiet_valid", 128'(out_valid), 128'(0));
    repeat (2) cyc();

    ch[3] = 32'h5;
    pc_in = 32'h10;
    exp_q.push_back(mk(16'd7, 32'h10, 5'd3, 32'h5, 1'b1, 1'b0));
    cyc();
    check("single_valid", 128'(out_valid), 128'(1));
    check("single_idx", 128'(out_idx), 128'(3));
    check("single_val", 128'(out_val), 128'(5));
    check("single_chg", 128'(out_chg), 128'(1));
    check("single_multi", 128'(out_multi), 128'(0));
    check("single_ts", 128'(out_ts), 128'(7));
    check("single_pc", 128'(out_pc), 128'(32'h10));

    ch[2] = 32'hAAAA;
    ch[9] = 32'h9999;
    pc_in = 32'h20;
    exp_q.push_back(mk(16'd8, 32'h20, 5'd2, 32'hAAAA, 1'b1, 1'b1));
    cyc();

    mode = MODE_ALL;
    for (int i = 0; i < 3; i++) begin
      pc_in = 32'h30 + i;
      exp_q.push_back(mk(ts_model, pc_in, 5'd0, 32'h0, 1'b0, 1'b0));
      cyc();
    end
    check("idle_level", 128'(level), 128'(5));
    drain(40);

    // Overflow: 20 pushes into 16 slots, last 4 dropped.
    out_ready = 1'b0;
    cap_en    = 1'b1;
    mode      = MODE_ALL;
    for (int i = 0; i < 20; i++) begin
      pc_in = 32'h100 + i;
      if (i < 16) exp_q.push_back(mk(ts_model, pc_in, 5'd0, 32'h0, 1'b0, 1'b0));
      cyc();
    end
    cap_en = 1'b0;
    check("ovf_level", 128'(level), 128'(16));
    check("ovf_flag", 128'(overflow), 128'(1));
    check("ovf_drop_cnt", 128'(drop_cnt), 128'(4));
    check("ovf_valid", 128'(out_valid), 128'(1));
    drain(40);
    check("ovf_sticky", 128'(overflow), 128'(1));

    // Refill, then push and pop together while full.
    out_ready = 1'b0;
    cap_en    = 1'b1;
    for (int i = 0; i < 16; i++) begin
      pc_in = 32'h200 + i;
      exp_q.push_back(mk(ts_model, pc_in, 5'd0, 32'h0, 1'b0, 1'b0));
      cyc();
    end
    check("refill_level", 128'(level), 128'(16));
    out_ready = 1'b1;
    pc_in     = 32'h300;
    exp_q.push_back(mk(ts_model, pc_in, 5'd0, 32'h0, 1'b0, 1'b0));
    cyc();
    check("fullpp_level", 128'(level), 128'(16));
    check("fullpp_drop_cnt", 128'(drop_cnt), 128'(4));
    cap_en = 1'b0;
    repeat (8) cyc();
    check("middrain_level", 128'(level), 128'(8));

    // Reset mid-drain discards everything at once.
    reset    = 1'b1;
    ts_model = '0;
    #1;
    check("rst_mid_valid", 128'(out_valid), 128'(0));
    check("rst_mid_level", 128'(level), 128'(0));
    check("rst_mid_overflow", 128'(overflow), 128'(0));
    exp_q.delete();
    cyc();
    cyc();
    reset     = 1'b0;
    ts_model  = '0;
    cap_en    = 1'b1;
    mode      = MODE_ALL;
    out_ready = 1'b0;
    pc_in     = 32'h3F0;
    cyc();
    check("reprime_level", 128'(level), 128'(0));
    check("reprime_valid", 128'(out_valid), 128'(0));
    pc_in = 32'h400;
    exp_q.push_back(mk(16'd1, 32'h400, 5'd0, 32'h0, 1'b0, 1'b0));
    cyc();
    check("post_rst_level", 128'(level), 128'(1));
    drain(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
